// File: rtl/ame_sched_pkg.sv
// Shared types for the AME solver scheduler: FSM states, issue tags and
// in-flight FIFO entries.
package ame_sched_pkg;

  localparam int TAG_BITS = 8;
  localparam int ID_BITS  = 2;
  localparam int SEQ_BITS = TAG_BITS - ID_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [SEQ_BITS-1:0] seq;
    logic [ID_BITS-1:0]  id;
  } tag_t;

  typedef struct packed {
    tag_t tag;
    logic param6;
  } fifo_entry_t;

endpackage

// File: rtl/ame_sched_tag_fifo.sv
// In-order FIFO of outstanding solver tags; head is visible combinationally.
// Push is ignored when full and pop when empty; simultaneous push/pop keeps count.
module ame_sched_tag_fifo
  import ame_sched_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  fifo_entry_t din_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output fifo_entry_t head_o
);

  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam logic [AW:0] FULL_CNT = MAX_INFLIGHT[AW:0];

  fifo_entry_t       r_mem [MAX_INFLIGHT];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/ame_solver_scheduler.sv
// Round-robin share of one equation solver among NUM_REQ requesters; issue
// takes T (ready) -> T+1 (init), responses return one cycle after done.
module ame_solver_scheduler
  import ame_sched_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int NUM_REQ        = 4,
  parameter int MAX_INFLIGHT   = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ-1:0]                   req_param6_i,
  input  logic [NUM_REQ*6*7*COMP_DATA_BITS-1:0] req_data_i,
  output logic                                 sol_init_o,
  input  logic                                 sol_load_i,
  input  logic                                 sol_done_i,
  output logic                                 sol_param6_o,
  output logic [6*7*COMP_DATA_BITS-1:0]        sol_data_o,
  output logic [TAG_BITS-1:0]                  sol_index_o,
  input  logic [6*COMP_DATA_BITS-1:0]          sol_data_i,
  input  logic [TAG_BITS-1:0]                  sol_index_i,
  output logic                                 rsp_valid_o,
  output logic [ID_BITS-1:0]                   rsp_id_o,
  output logic                                 rsp_param6_o,
  output logic [6*COMP_DATA_BITS-1:0]          rsp_data_o,
  output logic                                 err_o
);

  localparam int MAT_BITS = 6 * 7 * COMP_DATA_BITS;
  localparam int RES_BITS = 6 * COMP_DATA_BITS;
  localparam int SW       = ID_BITS + 1;

  state_e                r_state;
  logic [ID_BITS-1:0]    r_ptr;
  logic [SEQ_BITS-1:0]   r_seq;
  logic                  r_sol_init;
  logic                  r_sol_param6;
  logic [MAT_BITS-1:0]   r_sol_data;
  tag_t                  r_sol_index;
  logic                  r_rsp_valid;
  logic [ID_BITS-1:0]    r_rsp_id;
  logic                  r_rsp_param6;
  logic [RES_BITS-1:0]   r_rsp_data;
  logic                  r_err;

  logic [MAT_BITS-1:0]   w_req_mat [NUM_REQ];
  logic [ID_BITS-1:0]    w_grant;
  logic [ID_BITS-1:0]    w_idx;
  logic [SW-1:0]         w_sum;
  logic                  w_found;
  logic [ID_BITS-1:0]    w_ptr_next;
  logic                  w_accept;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_match;
  tag_t                  w_new_tag;
  fifo_entry_t           w_push_entry;
  fifo_entry_t           w_head;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_mat
    assign w_req_mat[g] = req_data_i[g*MAT_BITS +: MAT_BITS];
  end

  // First valid requester scanning upward from the round-robin pointer.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + SW'(i);
      if (w_sum >= SW'(NUM_REQ)) w_sum = w_sum - SW'(NUM_REQ);
      w_idx = w_sum[ID_BITS-1:0];
      if (!w_found && req_valid_i[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_ptr_next   = (w_grant == ID_BITS'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
  assign w_accept     = rst_n_i && (r_state == IDLE) && sol_load_i && w_found && !w_full;
  assign w_new_tag    = '{seq: r_seq, id: w_grant};
  assign w_push_entry = '{tag: w_new_tag, param6: req_param6_i[w_grant]};

  always_comb begin
    req_ready_o = '0;
    if (w_accept) req_ready_o[w_grant] = 1'b1;
  end

  // HOLD waits for the solver to drop load so a stale high level cannot re-issue.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_seq        <= '0;
      r_sol_init   <= 1'b0;
      r_sol_param6 <= 1'b0;
      r_sol_data   <= '0;
      r_sol_index  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sol_data   <= w_req_mat[w_grant];
            r_sol_param6 <= req_param6_i[w_grant];
            r_sol_index  <= w_new_tag;
            r_ptr        <= w_ptr_next;
            r_seq        <= r_seq + 1'b1;
            r_sol_init   <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_sol_init <= 1'b0;
          r_state    <= HOLD;
        end
        HOLD: begin
          if (!sol_load_i) r_state <= IDLE;
        end
        default: begin
          r_sol_init <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  ame_sched_tag_fifo #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_accept),
    .din_i   (w_push_entry),
    .pop_i   (sol_done_i),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  assign w_match = !w_empty && (sol_index_i == w_head.tag);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_param6 <= 1'b0;
      r_rsp_data   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_rsp_valid <= sol_done_i && w_match;
      if (sol_done_i && w_match) begin
        r_rsp_id     <= w_head.tag.id;
        r_rsp_param6 <= w_head.param6;
        r_rsp_data   <= sol_data_i;
      end
      if (sol_done_i && !w_match) r_err <= 1'b1;
    end
  end

  assign sol_init_o   = r_sol_init;
  assign sol_param6_o = r_sol_param6;
  assign sol_data_o   = r_sol_data;
  assign sol_index_o  = r_sol_index;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_id_o     = r_rsp_id;
  assign rsp_param6_o = r_rsp_param6;
  assign rsp_data_o   = r_rsp_data;
  assign err_o        = r_err;

endmodule

// File: doc/ame_solver_scheduler.md
# ame_solver_scheduler

Shares one `ame_equation_solver` instance between `NUM_REQ` affine-motion-estimation requesters. It round-robin arbitrates pending equation systems and issues each one to the solver with a unique 8-bit index tag. It tracks in-flight jobs in order and routes each solver result back to the requester that issued it. The block sits between the per-candidate AME accumulators and the solver.

## Interface
- `COMP_DATA_BITS`, 64, width of one matrix/result element.
- `NUM_REQ`, 4, number of requesters; 2..4.
- `MAX_INFLIGHT`, 4, depth of the in-flight tag FIFO; power of 2.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset. Asynchronous assert, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester job pending.
- `req_ready_o`  out  NUM_REQ  per-requester job accepted this cycle.
- `req_param6_i`  in  NUM_REQ  per-requester 6-parameter (1) / 4-parameter (0) flag.
- `req_data_i`  in  NUM_REQ×6×7×COMP_DATA_BITS  per-requester augmented matrix.
- `sol_init_o`  out  1  solver start pulse.
- `sol_load_i`  in  1  solver ready for a new job.
- `sol_done_i`  in  1  solver result valid.
- `sol_param6_o`  out  1  flag for the issued job.
- `sol_data_o`  out  6×7×COMP_DATA_BITS  matrix for the issued job.
- `sol_index_o`  out  8  tag for the issued job.
- `sol_data_i`  in  6×COMP_DATA_BITS  solver results.
- `sol_index_i`  in  8  tag returned with the results.
- `rsp_valid_o`  out  1  result pulse.
- `rsp_id_o`  out  2  destination requester.
- `rsp_param6_o`  out  1  flag of the returned job.
- `rsp_data_o`  out  6×COMP_DATA_BITS  results, X0..X5. X0/X1 are don't-care when `rsp_param6_o`=0.
- `err_o`  out  1  sticky protocol error.

## Operation
- **Tag format.** Tag = {seq[5:0], id[1:0]}. `seq` is a 6-bit issue counter. It increments per issued job and wraps 63→0.
- **FSM states:** IDLE, ISSUE, HOLD.
- **IDLE.** The block accepts a job when all of the following hold: `sol_load_i`=1, at least one `req_valid_i` bit is set, and the FIFO is not full. On acceptance:
  - Grant = first valid requester at or after the round-robin pointer.
  - `req_ready_o[grant]`=1 combinationally in that cycle.
  - The block latches data, param6 and tag into output registers.
  - It pushes {tag, param6} into the FIFO.
  - The pointer moves to grant+1 (mod NUM_REQ).
  - The FSM goes to ISSUE.
- **ISSUE.** `sol_init_o`=1 for exactly this one cycle. The FSM goes to HOLD.
- **HOLD.** The FSM stays here until `sol_load_i`=0 has been sampled at least once, then returns to IDLE. This prevents double issue on a stale load level.
- **Completion.** On `sol_done_i`=1, the block pops the FIFO head.
  - If `sol_index_i` equals the head tag, it registers the response: `rsp_id_o` = tag[1:0], `rsp_param6_o` from the FIFO.
  - If the tag mismatches, or the FIFO is empty, it sets `err_o`=1 and suppresses the response. The pop still occurs only if the FIFO is non-empty.
- **Simultaneous events.** A push and a pop in the same cycle are both honoured, with count unchanged. Full is evaluated before the push, so a same-cycle pop does not free a slot for that cycle's issue.
- **Holds.** `sol_*_o` outputs hold their last issued values until the next issue.
- **Starvation bound.** A requester holding valid is granted within NUM_REQ issues.

## Timing
- Reset values: `req_ready_o`=0, `sol_init_o`=0, `sol_param6_o`=0, `sol_data_o`=0, `sol_index_o`=0, `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_param6_o`=0, `rsp_data_o`=0, `err_o`=0. The FSM resets to IDLE, pointer=0, seq=0, FIFO empty.
- Issue latency: the `req_ready_o` cycle is T. `sol_init_o` is high in T+1. The earliest next acceptance is T+3 (HOLD needs `sol_load_i`=0 in T+2).
- Response latency: `rsp_*` is valid in the cycle after `sol_done_i`. `rsp_valid_o` is a one-cycle pulse with no backpressure. Requesters must always sink it.
- Reset mid-operation: all state clears immediately. Solver jobs already in flight are orphaned. A later `sol_done_i` with an empty FIFO raises `err_o`; the bench resets the solver together with this block.

## Structure
- Package `ame_sched_pkg` holds:
  - the FSM state enum (IDLE/ISSUE/HOLD);
  - the packed tag struct {seq, id};
  - the FIFO entry struct {tag, param6};
  - constants `TAG_BITS`=8 and `ID_BITS`=2.
- Sub-module `ame_sched_tag_fifo` is a synchronous FIFO with parameter MAX_INFLIGHT and ports push, pop, full, empty, head. The arbiter and FSM live in the top module.

## Test plan
- **Single job.** Requester 2 valid, `sol_load_i`=1 → `req_ready_o`=0100 in T; `sol_init_o` in T+1 with `sol_index_o`=0x02. A solver done with index 0x02 and X2=1405 → `rsp_valid_o` next cycle, `rsp_id_o`=2, `rsp_data_o[2]`=1405.
- **Round robin.** All four requesters valid continuously → issue order is ids 0,1,2,3,0 with tags 0x00, 0x05, 0x0A, 0x0F, 0x10.
- **FIFO full.** Hold `sol_done_i`=0 with requesters valid → exactly 4 issues, then `req_ready_o` stays 0. One done → exactly one more issue.
- **Error paths.** Done with index 0x07 while the head is 0x04 → `err_o`=1, no `rsp_valid_o`, FIFO count decreases by 1. A done on an empty FIFO → `err_o`=1.
- **seq wrap.** 64 jobs from requester 0 → the 65th tag is 0x00 and its response is still routed correctly.
- **Mid-run reset.** Reset asserted in HOLD with 2 jobs in flight → all outputs return to their reset values asynchronously. After release, the first issue has tag 0x00 from requester 0.
